// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with stall/flush handling and one-cycle load-use bubble insertion.
// Optional macro LOAD_USE_DETECT_EN enables load-use hazard detection; undefined ties load_use low.
module id_ex_pipe_reg #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_src_data1,
    input  logic [DATA_W-1:0]   id_src_data2,
    input  logic [REG_AW-1:0]   id_src_reg1,
    input  logic [REG_AW-1:0]   id_src_reg2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [REG_AW-1:0]   id_dst_reg,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic                ex_stall,
    input  logic                flush,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_src_data1,
    output logic [DATA_W-1:0]   ex_src_data2,
    output logic [REG_AW-1:0]   ex_src_reg1,
    output logic [REG_AW-1:0]   ex_src_reg2,
    output logic                ex_use1,
    output logic                ex_use2,
    output logic [REG_AW-1:0]   ex_dst_reg,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]   ex_imm,
    output logic                id_stall,
    output logic                load_use
);

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   srcData1;
        logic [DATA_W-1:0]   srcData2;
        logic [REG_AW-1:0]   srcReg1;
        logic [REG_AW-1:0]   srcReg2;
        logic                use1;
        logic                use2;
        logic [REG_AW-1:0]   dstReg;
        logic                regWrite;
        logic                memRead;
        logic                memWrite;
        logic [ALU_OP_W-1:0] aluOp;
        logic [DATA_W-1:0]   imm;
    } stageBundle_t;

    stageBundle_t idBundle;
    stageBundle_t exBundle;
    logic         loadUse;

    assign idBundle = '{
        valid:    id_valid,
        srcData1: id_src_data1,
        srcData2: id_src_data2,
        srcReg1:  id_src_reg1,
        srcReg2:  id_src_reg2,
        use1:     id_use1,
        use2:     id_use2,
        dstReg:   id_dst_reg,
        regWrite: id_reg_write,
        memRead:  id_mem_read,
        memWrite: id_mem_write,
        aluOp:    id_alu_op,
        imm:      id_imm
    };

`ifdef LOAD_USE_DETECT_EN
    // A load into R0 never produces a value a consumer waits on.
    assign loadUse = exBundle.valid & exBundle.memRead & (exBundle.dstReg != '0) & id_valid &
                     ((id_use1 & (id_src_reg1 == exBundle.dstReg)) |
                      (id_use2 & (id_src_reg2 == exBundle.dstReg)));
`else
    assign loadUse = 1'b0;
`endif

    assign load_use = loadUse;
    // Gated by reset so fetch/decode is never held while the core is in reset.
    assign id_stall = rst & (ex_stall | loadUse);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exBundle <= '0;
        end else if (flush) begin
            exBundle <= '0;
        end else if (ex_stall) begin
            exBundle <= exBundle;
        end else if (loadUse) begin
            exBundle <= '0;
        end else begin
            exBundle <= id_valid ? idBundle : '0;
        end
    end

    assign ex_valid     = exBundle.valid;
    assign ex_src_data1 = exBundle.srcData1;
    assign ex_src_data2 = exBundle.srcData2;
    assign ex_src_reg1  = exBundle.srcReg1;
    assign ex_src_reg2  = exBundle.srcReg2;
    assign ex_use1      = exBundle.use1;
    assign ex_use2      = exBundle.use2;
    assign ex_dst_reg   = exBundle.dstReg;
    assign ex_reg_write = exBundle.regWrite;
    assign ex_mem_read  = exBundle.memRead;
    assign ex_mem_write = exBundle.memWrite;
    assign ex_alu_op    = exBundle.aluOp;
    assign ex_imm       = exBundle.imm;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; load-use steps adapt to LOAD_USE_DETECT_EN.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [15:0] id_src_data1, id_src_data2, id_imm;
    logic [3:0]  id_src_reg1, id_src_reg2, id_dst_reg, id_alu_op;
    logic        id_use1, id_use2, id_reg_write, id_mem_read, id_mem_write;
    logic        ex_stall, flush;
    logic        ex_valid;
    logic [15:0] ex_src_data1, ex_src_data2, ex_imm;
    logic [3:0]  ex_src_reg1, ex_src_reg2, ex_dst_reg, ex_alu_op;
    logic        ex_use1, ex_use2, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        id_stall, load_use;

    int checks = 0;
    int failures = 0;
    logic [15:0] rd1, rd2, rimm;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src_data1(id_src_data1), .id_src_data2(id_src_data2),
        .id_src_reg1(id_src_reg1), .id_src_reg2(id_src_reg2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dst_reg(id_dst_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_op(id_alu_op), .id_imm(id_imm),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_src_data1(ex_src_data1), .ex_src_data2(ex_src_data2),
        .ex_src_reg1(ex_src_reg1), .ex_src_reg2(ex_src_reg2),
        .ex_use1(ex_use1), .ex_use2(ex_use2), .ex_dst_reg(ex_dst_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_imm(ex_imm),
        .id_stall(id_stall), .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIns(input logic v, input logic [15:0] d1, input logic [15:0] d2,
                          input logic [3:0] r1, input logic [3:0] r2, input logic u1, input logic u2,
                          input logic [3:0] dst, input logic rw, input logic mr, input logic mw,
                          input logic [3:0] alu, input logic [15:0] imm);
        id_valid = v; id_src_data1 = d1; id_src_data2 = d2;
        id_src_reg1 = r1; id_src_reg2 = r2; id_use1 = u1; id_use2 = u2;
        id_dst_reg = dst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_alu_op = alu; id_imm = imm;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random decode inputs and a pending stall request.
        rst = 1'b0; flush = 1'b0; ex_stall = 1'b1;
        setIns(1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1,
               4'($urandom), 1'b1, 1'b1, 1'b1, 4'($urandom), 16'($urandom));
        step(); step();
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_ex_data1", ex_src_data1, 0);
        chk("reset_ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_dst_reg}, 0);
        chk("reset_id_stall", id_stall, 0);
        chk("reset_load_use", load_use, 0);

        // Release between edges; the next edge captures the decode inputs.
        rst = 1'b1; ex_stall = 1'b0;
        rd1 = 16'($urandom); rd2 = 16'($urandom); rimm = 16'($urandom);
        setIns(1'b1, rd1, rd2, 4'd9, 4'd10, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 4'd6, rimm);
        #1;
        chk("release_ex_valid", ex_valid, 0);
        chk("release_id_stall", id_stall, 0);
        step();
        chk("first_cap_valid", ex_valid, 1);
        chk("first_cap_data", {ex_src_data1, ex_src_data2}, {rd1, rd2});
        chk("first_cap_imm", ex_imm, rimm);
        chk("first_cap_ctrl", {ex_src_reg1, ex_src_reg2, ex_use1, ex_use2, ex_dst_reg,
                               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op},
                              {4'd9, 4'd10, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 4'd6});

        // Pass-through.
        setIns(1'b1, 16'h1234, 16'hABCD, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd3, 16'h00FF);
        step();
        chk("pass_valid", ex_valid, 1);
        chk("pass_data", {ex_src_data1, ex_src_data2}, 32'h1234ABCD);
        chk("pass_dst_alu", {ex_dst_reg, ex_alu_op}, {4'd5, 4'd3});
        chk("pass_regs", {ex_src_reg1, ex_src_reg2, ex_use1, ex_use2}, {4'd1, 4'd2, 2'b11});
        chk("pass_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b100);
        chk("pass_imm", ex_imm, 16'h00FF);

        // id_valid=0 is captured as an all-zero bubble.
        setIns(1'b0, 16'hDEAD, 16'hBEEF, 4'd3, 4'd4, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 4'd9, 16'h5555);
        step();
        chk("invalid_bubble_valid", ex_valid, 0);
        chk("invalid_bubble_fields", {ex_src_data1, ex_dst_reg, ex_reg_write, ex_mem_read, ex_mem_write}, 0);

        // Load to R3 followed by a consumer of R3.
        setIns(1'b1, 16'h0100, 16'h0000, 4'd2, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0004);
        step();
        chk("load_in_ex", {ex_valid, ex_mem_read, ex_dst_reg}, {1'b1, 1'b1, 4'd3});
        setIns(1'b1, 16'h1111, 16'h2222, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd1, 16'h0000);
        #1;
`ifdef LOAD_USE_DETECT_EN
        chk("lu_load_use", load_use, 1);
        chk("lu_id_stall", id_stall, 1);
        step();
        chk("lu_bubble", {ex_valid, ex_mem_read, ex_reg_write, ex_dst_reg}, 0);
        chk("lu_clear", {load_use, id_stall}, 2'b00);
        step();
`else
        chk("nolu_load_use", load_use, 0);
        chk("nolu_id_stall", id_stall, 0);
        step();
`endif
        chk("dep_advance", {ex_valid, ex_dst_reg, ex_src_data1}, {1'b1, 4'd6, 16'h1111});

        // Load to R0 never stalls a consumer of R0.
        setIns(1'b1, 16'h0000, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000);
        step();
        setIns(1'b1, 16'h3333, 16'h0000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0000);
        #1;
        chk("r0_load_use", {load_use, id_stall}, 2'b00);
        step();
        chk("r0_advance", {ex_valid, ex_dst_reg, ex_src_data1}, {1'b1, 4'd8, 16'h3333});

        // Load to R12; consumer reads R12 only via src2.
        setIns(1'b1, 16'h0000, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000);
        step();
        setIns(1'b1, 16'h4444, 16'h5555, 4'd1, 4'd12, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0000);
        #1;
`ifdef LOAD_USE_DETECT_EN
        chk("src2_load_use", load_use, 1);
`else
        chk("src2_load_use", load_use, 0);
`endif
        // Same register index but use2=0: not a hazard.
        id_use2 = 1'b0;
        #1;
        chk("src2_unused", {load_use, id_stall}, 2'b00);
        step();
        chk("src2_unused_adv", {ex_valid, ex_src_data2}, {1'b1, 16'h5555});

        // Stall hold for three cycles with changing decode inputs.
        setIns(1'b1, 16'hAAAA, 16'h0000, 4'd1, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0000);
        step();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setIns(1'b1, 16'(16'h0B00 + i), 16'h0000, 4'd1, 4'd2, 1'b1, 1'b0, 4'(i + 8), 1'b1, 1'b0, 1'b1, 4'd2, 16'h0000);
            #1;
            chk("stall_id_stall", id_stall, 1);
            step();
            chk("stall_hold", {ex_valid, ex_src_data1, ex_dst_reg, ex_mem_write}, {1'b1, 16'hAAAA, 4'd7, 1'b0});
        end
        ex_stall = 1'b0;
        setIns(1'b1, 16'hC0DE, 16'h0000, 4'd1, 4'd2, 1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0000);
        step();
        chk("stall_resume", {ex_valid, ex_src_data1, ex_dst_reg, ex_mem_write}, {1'b1, 16'hC0DE, 4'd13, 1'b1});

        // A bubble is held through a stall as well.
        id_valid = 1'b0;
        step();
        ex_stall = 1'b1; id_valid = 1'b1;
        step();
        chk("stall_hold_bubble", {ex_valid, ex_src_data1}, 0);
        ex_stall = 1'b0;

        // Flush beats stall and load-use.
        setIns(1'b1, 16'h0000, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000);
        step();
        setIns(1'b1, 16'h7777, 16'h0000, 4'd4, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0000);
        ex_stall = 1'b1; flush = 1'b1;
        #1;
`ifdef LOAD_USE_DETECT_EN
        chk("flush_load_use", load_use, 1);
`endif
        chk("flush_id_stall", id_stall, 1);
        step();
        chk("flush_bubble", {ex_valid, ex_reg_write, ex_mem_write, ex_mem_read, ex_dst_reg}, 0);
        ex_stall = 1'b0; flush = 1'b0;
        step();
        chk("post_flush_capture", {ex_valid, ex_src_data1, ex_mem_write}, {1'b1, 16'h7777, 1'b1});

        // Asynchronous reset between edges.
        chk("pre_async_valid", ex_valid, 1);
        #2 rst = 1'b0; ex_stall = 1'b1;
        #1;
        chk("async_ex_valid", ex_valid, 0);
        chk("async_ex_data", {ex_src_data1, ex_dst_reg, ex_mem_write}, 0);
        chk("async_id_stall", id_stall, 0);
        step();
        #2 rst = 1'b1; ex_stall = 1'b0;
        setIns(1'b1, 16'h9999, 16'h8888, 4'd5, 4'd6, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 4'd8, 16'h0001);
        step();
        chk("post_reset_capture", {ex_valid, ex_src_data1, ex_src_data2, ex_dst_reg}, {1'b1, 16'h9999, 16'h8888, 4'd14});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
